// File: rtl/alu_md_control.sv
// ALU control: combinational ALUOp/func decode plus an iterative unsigned multiply/divide
// engine (shift-add multiply, restoring divide) that owns the HI/LO registers.
module alu_md_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [4:0]       ALUOperation,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_JR   = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_md_func;
    logic               w_start_mul;
    logic               w_start_div;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    // Multiplier sits in the low half of the accumulator and is consumed LSB first.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit; keep the difference only if no borrow.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

    assign w_last = (r_cnt == CNT_ONE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ALUOperation = 5'd0;
        w_md_func    = 1'b0;
        case (ALUOp)
            2'b01: ALUOperation = 5'd0;
            2'b10: ALUOperation = 5'd1;
            2'b11: ALUOperation = 5'd5;
            default: begin
                case (func)
                    F_ADD:  ALUOperation = 5'd0;
                    F_SUB:  ALUOperation = 5'd1;
                    F_AND:  ALUOperation = 5'd2;
                    F_OR:   ALUOperation = 5'd3;
                    F_XOR:  ALUOperation = 5'd4;
                    F_SLT:  ALUOperation = 5'd5;
                    F_MULT: begin ALUOperation = 5'd14; w_md_func = 1'b1; end
                    F_DIV:  begin ALUOperation = 5'd13; w_md_func = 1'b1; end
                    F_MFLO: begin ALUOperation = 5'd11; w_md_func = 1'b1; end
                    F_MFHI: begin ALUOperation = 5'd12; w_md_func = 1'b1; end
                    F_JR:   ALUOperation = 5'd0;
                    default: ALUOperation = 5'd0;
                endcase
            end
        endcase
    end

    always_comb begin
        w_start_mul = start && (ALUOp == 2'b00) && (func == F_MULT);
        w_start_div = start && (ALUOp == 2'b00) && (func == F_DIV) && (B != '0);
        w_div_zero  = start && (ALUOp == 2'b00) && (func == F_DIV) && (B == '0);

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_mul)      w_state_nxt = S_MUL;
                else if (w_start_div) w_state_nxt = S_DIV;
                else if (w_div_zero)  w_state_nxt = S_DONE;
            end
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase

        busy  = (r_state == S_MUL) || (r_state == S_DIV);
        done  = (r_state == S_DONE);
        stall = start && w_md_func && (busy || done);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_mul) begin
                        r_mcand <= A;
                        r_acc   <= {{WIDTH{1'b0}}, B};
                        r_cnt   <= CNT_INIT;
                    end else if (w_start_div) begin
                        r_dvs <= B;
                        r_quo <= A;
                        r_rem <= '0;
                        r_cnt <= CNT_INIT;
                    end else if (w_div_zero) begin
                        r_hi <= A;
                        r_lo <= '1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        r_lo <= w_acc_nxt[WIDTH-1:0];
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_hi <= w_rem_nxt;
                        r_lo <= w_quo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_alu_md_control.sv
// Scoreboard bench for alu_md_control: decode table, mult/div results and latency,
// stall on md-class requests while busy, and reset in the middle of an operation.
module tb_alu_md_control;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_ADD  = 6'b100000;

    logic             clk;
    logic             rst;
    logic [1:0]       ALUOp;
    logic [5:0]       func;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       ALUOperation;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    alu_md_control #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUOp        (ALUOp),
        .func         (func),
        .start        (start),
        .A            (A),
        .B            (B),
        .ALUOperation (ALUOperation),
        .busy         (busy),
        .stall        (stall),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               accept;
        int               lat;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic       st;
        logic [4:0] exp;
    } dec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result checker: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("latency", cyc - e.accept, e.lat);
            end
        end
    end

    // Presents a mult/div in IDLE, returns at the negedge after the accepting edge.
    task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t        e;
        logic [63:0] prod;
        @(negedge clk);
        ALUOp = 2'b00;
        func  = f;
        A     = a;
        B     = b;
        start = 1'b1;
        #1;
        check("stall_at_issue", stall, 1'b0);
        e.accept = cyc + 1;
        e.lat    = WIDTH;
        if (f == F_MULT) begin
            prod = 64'(a) * 64'(b);
            e.hi = prod[63:32];
            e.lo = prod[31:0];
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.lat = 0;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
        end
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic run_md(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_busy);
        int n;
        issue(f, a, b);
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        check("done_seen", done, 1'b1);
        check("busy_cycles", n, exp_busy);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("sb_drain", sb.size(), 0);
    endtask

    dec_t dec_tbl[16] = '{
        '{2'b00, 6'b100000, 1'b1, 5'd0},  '{2'b00, 6'b100010, 1'b1, 5'd1},
        '{2'b00, 6'b100100, 1'b1, 5'd2},  '{2'b00, 6'b100101, 1'b1, 5'd3},
        '{2'b00, 6'b100110, 1'b1, 5'd4},  '{2'b00, 6'b101010, 1'b1, 5'd5},
        '{2'b00, 6'b011000, 1'b0, 5'd14}, '{2'b00, 6'b011010, 1'b0, 5'd13},
        '{2'b00, 6'b010010, 1'b1, 5'd11}, '{2'b00, 6'b010000, 1'b1, 5'd12},
        '{2'b00, 6'b001000, 1'b1, 5'd0},  '{2'b00, 6'b111111, 1'b1, 5'd0},
        '{2'b01, 6'b100010, 1'b1, 5'd0},  '{2'b10, 6'b100000, 1'b1, 5'd1},
        '{2'b11, 6'b011000, 1'b1, 5'd5},  '{2'b11, 6'b111111, 1'b1, 5'd5}
    };

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        ALUOp = 2'b00;
        func  = 6'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst = 1'b0;

        // Decode table; the engine must never start from any of these.
        foreach (dec_tbl[i]) begin
            @(negedge clk);
            ALUOp = dec_tbl[i].op;
            func  = dec_tbl[i].fn;
            start = dec_tbl[i].st;
            #1;
            check("decode", ALUOperation, dec_tbl[i].exp);
            check("decode_busy", busy, 1'b0);
            check("decode_stall", stall, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        check("decode_busy_end", busy, 1'b0);

        run_md(F_MULT, 32'd7, 32'd6, WIDTH);
        run_md(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, WIDTH);
        run_md(F_DIV, 32'd100, 32'd7, WIDTH);
        run_md(F_DIV, 32'd5, 32'd0, 0);
        for (int i = 0; i < 3; i++) begin
            run_md(F_MULT, $urandom, $urandom, WIDTH);
            run_md(F_DIV, $urandom, $urandom_range(1, 1000), WIDTH);
            run_md(F_DIV, $urandom_range(0, 50), $urandom, WIDTH);
        end

        // mfhi held while the engine runs: stalled through MUL and DONE, then accepted.
        issue(F_MULT, 32'd3, 32'd5);
        ALUOp = 2'b00;
        func  = F_MFHI;
        start = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            check("mfhi_op", ALUOperation, 5'd12);
            n++;
            @(negedge clk);
            #1;
        end
        check("mfhi_stall_cycles", n, WIDTH + 1);
        check("mfhi_accept_busy", busy, 1'b0);
        check("mfhi_accept_done", done, 1'b0);
        check("mfhi_lo", lo, 32'd15);
        @(negedge clk);
        start = 1'b0;
        check("mfhi_no_start", busy, 1'b0);
        check("mfhi_sb_drain", sb.size(), 0);

        // Non-md instruction while busy, then reset in the middle of the mult.
        issue(F_MULT, 32'd9, 32'd9);
        ALUOp = 2'b00;
        func  = F_ADD;
        start = 1'b1;
        #1;
        check("nonmd_stall", stall, 1'b0);
        check("nonmd_op", ALUOperation, 5'd0);
        check("nonmd_busy", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", busy, 1'b0);
        run_md(F_MULT, 32'd123456, 32'd789, WIDTH);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
